// File: rtl/clk_div_pkg.sv
// Shared constants and config clamping for the programmable clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int MIN_DIV   = 2;

  typedef struct packed {
    logic [31:0] div;
    logic [31:0] high;
  } cfg_pair_t;

  // Keeps duty strictly between 0% and 100%: div >= 2, 1 <= high <= div-1.
  function automatic cfg_pair_t clamp_cfg(input logic [31:0] div, input logic [31:0] high);
    cfg_pair_t r;
    r.div = (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
    if (high == 32'd0)
      r.high = 32'd1;
    else if (high >= r.div)
      r.high = r.div - 32'd1;
    else
      r.high = high;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active config, registered clock and edge strobes.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV  = CNT_W'(10),
  parameter logic [CNT_W-1:0] RST_HIGH = CNT_W'(5)
) (
  input  logic             clk_100m,
  input  logic             rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cfg_div,
  input  logic [CNT_W-1:0] i_cfg_high,
  input  logic             i_cfg_load,
  input  logic             i_sync,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_pending
);

  localparam cfg_pair_t        RST_CFG    = clamp_cfg(32'(RST_DIV), 32'(RST_HIGH));
  localparam logic [CNT_W-1:0] RST_DIV_C  = CNT_W'(RST_CFG.div);
  localparam logic [CNT_W-1:0] RST_HIGH_C = CNT_W'(RST_CFG.high);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_act;
  logic [CNT_W-1:0] r_high_act;
  logic [CNT_W-1:0] r_div_sh;
  logic [CNT_W-1:0] r_high_sh;
  logic             r_pending;
  logic             r_clk;
  logic             r_rise;
  logic             r_fall;

  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_div_src;
  logic [CNT_W-1:0] w_high_src;
  cfg_pair_t        w_clamp;
  logic [CNT_W-1:0] w_cnt_eval;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_clk_next;

  assign w_wrap     = (r_cnt == r_div_act - CNT_W'(1));
  assign w_apply    = ~i_en | i_sync | w_wrap;
  // A load coinciding with an apply bypasses the shadow.
  assign w_div_src  = i_cfg_load ? i_cfg_div  : r_div_sh;
  assign w_high_src = i_cfg_load ? i_cfg_high : r_high_sh;
  assign w_clamp    = clamp_cfg(32'(w_div_src), 32'(w_high_src));
  // sync restarts the phase: this cycle is evaluated as if cnt were 0.
  assign w_cnt_eval = i_sync ? '0 : r_cnt;
  assign w_clk_next = i_en & (w_cnt_eval < r_high_act);

  always_comb begin
    w_cnt_next = r_cnt + CNT_W'(1);
    if (!i_en || i_sync || w_wrap)
      w_cnt_next = '0;
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      r_cnt      <= '0;
      r_clk      <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_pending  <= 1'b0;
      r_div_act  <= RST_DIV_C;
      r_high_act <= RST_HIGH_C;
      r_div_sh   <= RST_DIV_C;
      r_high_sh  <= RST_HIGH_C;
    end else begin
      r_cnt  <= w_cnt_next;
      r_clk  <= w_clk_next;
      r_rise <= w_clk_next & ~r_clk;
      r_fall <= ~w_clk_next & r_clk;
      if (i_cfg_load) begin
        r_div_sh  <= i_cfg_div;
        r_high_sh <= i_cfg_high;
      end
      if (w_apply) begin
        r_div_act  <= CNT_W'(w_clamp.div);
        r_high_act <= CNT_W'(w_clamp.high);
        r_pending  <= 1'b0;
      end else if (i_cfg_load) begin
        r_pending  <= 1'b1;
      end
    end
  end

  assign o_clk     = r_clk;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_pending = r_pending;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider; slices flat config buses per channel.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] RST_DIV  = {8'd4, 8'd10},
  parameter logic [NUM_CH*CNT_W-1:0] RST_HIGH = {8'd2, 8'd5}
) (
  input  logic                    clk_100m,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] cfg_div,
  input  logic [NUM_CH*CNT_W-1:0] cfg_high,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       stb_rise,
  output logic [NUM_CH-1:0]       stb_fall,
  output logic [NUM_CH-1:0]       cfg_pending
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clk_div_chan #(
        .CNT_W    (CNT_W),
        .RST_DIV  (RST_DIV[gi*CNT_W +: CNT_W]),
        .RST_HIGH (RST_HIGH[gi*CNT_W +: CNT_W])
      ) u_chan (
        .clk_100m   (clk_100m),
        .rst        (rst),
        .i_en       (ch_en[gi]),
        .i_cfg_div  (cfg_div[gi*CNT_W +: CNT_W]),
        .i_cfg_high (cfg_high[gi*CNT_W +: CNT_W]),
        .i_cfg_load (cfg_load[gi]),
        .i_sync     (sync),
        .o_clk      (clk_out[gi]),
        .o_rise     (stb_rise[gi]),
        .o_fall     (stb_fall[gi]),
        .o_pending  (cfg_pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: vector table plus hand-built sequences, scoreboard queue.
module tb_clk_div_prog;

  logic        clk_100m = 1'b0;
  logic        rst;
  logic [1:0]  ch_en;
  logic [15:0] cfg_div;
  logic [15:0] cfg_high;
  logic [1:0]  cfg_load;
  logic        sync;
  logic [1:0]  clk_out;
  logic [1:0]  stb_rise;
  logic [1:0]  stb_fall;
  logic [1:0]  cfg_pending;

  always #5 clk_100m = ~clk_100m;

  clk_div_prog #(.NUM_CH(2), .CNT_W(8)) dut (
    .clk_100m    (clk_100m),
    .rst         (rst),
    .ch_en       (ch_en),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .cfg_load    (cfg_load),
    .sync        (sync),
    .clk_out     (clk_out),
    .stb_rise    (stb_rise),
    .stb_fall    (stb_fall),
    .cfg_pending (cfg_pending)
  );

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic [1:0] load;
    logic [7:0] d0, h0, d1, h1;
    logic       sync;
    logic [1:0] clk;
    logic [1:0] pend;
  } vec_t;

  typedef struct {
    string      tag;
    logic [1:0] clk, rise, fall, pend;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [1:0] prev_clk = 2'b00;

  function automatic vec_t mk(input logic r, input logic [1:0] en, input logic [1:0] ld,
                              input logic [7:0] d0, input logic [7:0] h0,
                              input logic [7:0] d1, input logic [7:0] h1,
                              input logic s, input logic [1:0] c, input logic [1:0] p);
    vec_t v;
    v.rst = r; v.en = en; v.load = ld;
    v.d0 = d0; v.h0 = h0; v.d1 = d1; v.h1 = h1;
    v.sync = s; v.clk = c; v.pend = p;
    return v;
  endfunction

  task automatic check(input string tag, input string what, input logic [1:0] got, input logic [1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %b expected %b", tag, what, got, exp);
    end
  endtask

  // Strobes are derived from the expected clock sequence; reset forces them low.
  task automatic apply(input string tag, input vec_t v);
    exp_t e;
    rst      = v.rst;
    ch_en    = v.en;
    cfg_load = v.load;
    cfg_div  = {v.d1, v.d0};
    cfg_high = {v.h1, v.h0};
    sync     = v.sync;
    e.tag  = tag;
    e.clk  = v.clk;
    e.pend = v.pend;
    e.rise = v.rst ? 2'b00 : (v.clk & ~prev_clk);
    e.fall = v.rst ? 2'b00 : (~v.clk & prev_clk);
    prev_clk = v.clk;
    sb.push_back(e);
    @(posedge clk_100m);
    #1;
    e = sb.pop_front();
    $display("[%s] rst=%b en=%b load=%b sync=%b clk_out=%b rise=%b fall=%b pend=%b",
             e.tag, v.rst, v.en, v.load, v.sync, clk_out, stb_rise, stb_fall, cfg_pending);
    check(e.tag, "clk_out", clk_out, e.clk);
    check(e.tag, "stb_rise", stb_rise, e.rise);
    check(e.tag, "stb_fall", stb_fall, e.fall);
    check(e.tag, "cfg_pending", cfg_pending, e.pend);
  endtask

  task automatic do_reset();
    apply("reset", mk(1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00));
    apply("reset", mk(1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00));
  endtask

  vec_t tbl[21];

  initial begin
    logic c0, c1;

    // Clamp / last-wins table on ch0 (ch1 held disabled).
    tbl[0]  = mk(1'b0, 2'b00, 2'b01, 8'd1, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00);
    tbl[1]  = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00);
    tbl[2]  = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00);
    tbl[3]  = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00);
    tbl[4]  = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00);
    tbl[5]  = mk(1'b0, 2'b00, 2'b01, 8'd5, 8'd9, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00);
    tbl[6]  = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00);
    tbl[7]  = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00);
    tbl[8]  = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00);
    tbl[9]  = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00);
    tbl[10] = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00);
    tbl[11] = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00);
    tbl[12] = mk(1'b0, 2'b01, 2'b01, 8'd3, 8'd1, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01);
    tbl[13] = mk(1'b0, 2'b01, 2'b01, 8'd4, 8'd2, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01);
    tbl[14] = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01);
    tbl[15] = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00);
    tbl[16] = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00);
    tbl[17] = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00);
    tbl[18] = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00);
    tbl[19] = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00);
    tbl[20] = mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00);

    // Reset defaults: ch0 10/5, ch1 4/2.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      c0 = ((k - 1) % 10) < 5;
      c1 = ((k - 1) % 4) < 2;
      apply("defaults", mk(1'b0, 2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, {c1, c0}, 2'b00));
    end

    // Load 6/2 at cnt=3: current period finishes, new config from the next period.
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      c0 = (k <= 10) ? (((k - 1) % 10) < 5) : (((k - 11) % 6) < 2);
      apply("deferred", mk(1'b0, 2'b01, (k == 4) ? 2'b01 : 2'b00, 8'd6, 8'd2, 8'd0, 8'd0,
                           1'b0, {1'b0, c0}, {1'b0, (k >= 4 && k <= 9)}));
    end

    do_reset();
    for (int i = 0; i < 21; i++) apply("clamp", tbl[i]);

    // sync aligns ch0 and ch1 (both 10/5) from different phases.
    do_reset();
    apply("sync_setup", mk(1'b0, 2'b00, 2'b10, 8'd0, 8'd0, 8'd10, 8'd5, 1'b0, 2'b00, 2'b00));
    for (int k = 1; k <= 3; k++)
      apply("sync_pre", mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00));
    apply("sync_pre", mk(1'b0, 2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b11, 2'b00));
    apply("sync_pre", mk(1'b0, 2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b11, 2'b00));
    apply("sync_pre", mk(1'b0, 2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b10, 2'b00));
    apply("sync_pre", mk(1'b0, 2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b10, 2'b00));
    apply("sync", mk(1'b0, 2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 2'b11, 2'b00));
    for (int j = 1; j <= 20; j++) begin
      c0 = ((j - 1) % 10) < 5;
      apply("sync_post", mk(1'b0, 2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, {c0, c0}, 2'b00));
    end

    // Disable while high, then re-enable with a full high time.
    do_reset();
    for (int k = 1; k <= 3; k++)
      apply("dis_pre", mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00));
    apply("disable", mk(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00));
    apply("disable", mk(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00));
    for (int k = 1; k <= 7; k++) begin
      c0 = ((k - 1) % 10) < 5;
      apply("reenable", mk(1'b0, 2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, {1'b0, c0}, 2'b00));
    end

    // Reset mid-period with a load pending restores the reset configuration.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      c1 = ((k - 1) % 4) < 2;
      apply("rst_pre", mk(1'b0, 2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, {c1, 1'b1}, 2'b00));
    end
    apply("rst_load", mk(1'b0, 2'b11, 2'b01, 8'd6, 8'd2, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01));
    apply("rst_mid", mk(1'b1, 2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00));
    for (int k = 1; k <= 16; k++) begin
      c0 = ((k - 1) % 10) < 5;
      c1 = ((k - 1) % 4) < 2;
      apply("rst_post", mk(1'b0, 2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, {c1, c0}, 2'b00));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
